// File: rtl/pair_xfer_sequencer_if.sv
// rtl/pair_xfer_sequencer_if.sv - control/strobe bundle between top-level control and the pair transfer sequencer
interface pair_xfer_sequencer_if;
  logic       start;
  logic       stall;
  logic       weA;
  logic       incA;
  logic       clrA;
  logic       weB;
  logic       incB;
  logic       clrB;
  logic       busy;
  logic       done;
  logic [2:0] phase;

  modport master (
    output start, stall,
    input  weA, incA, clrA, weB, incB, clrB, busy, done, phase
  );

  modport slave (
    input  start, stall,
    output weA, incA, clrA, weB, incB, clrB, busy, done, phase
  );
endinterface

// File: rtl/pair_xfer_sequencer.sv
// rtl/pair_xfer_sequencer.sv - loads A_DEPTH words into memory A, then reduces A pairwise into memory B
// Strobes are registered from the next state, so each output reflects the state entered at the last edge.
module pair_xfer_sequencer #(
  parameter int A_DEPTH = 8,
  parameter int CNT_W   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  pair_xfer_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_LOAD   = 3'd2,
    S_REWIND = 3'd3,
    S_PROC   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SUB_R0 = 2'd0,
    SUB_R1 = 2'd1,
    SUB_W  = 2'd2
  } sub_t;

  localparam logic [CNT_W-1:0] LOAD_END = CNT_W'(A_DEPTH);
  localparam logic [CNT_W-1:0] PAIR_END = CNT_W'(A_DEPTH / 2);

  state_t           r_state;
  sub_t             r_sub;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bubble;
  logic             r_weA, r_incA, r_clrA, r_weB, r_incB, r_clrB, r_busy, r_done;

  state_t           w_state_nxt;
  sub_t             w_sub_nxt;
  sub_t             w_sub_adv;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_adv;
  logic             w_bubble_nxt;
  logic             w_active;
  logic             w_weA, w_incA, w_clrA, w_weB, w_incB, w_clrB, w_busy, w_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_sub    <= SUB_R0;
      r_cnt    <= '0;
      r_bubble <= 1'b0;
      r_weA    <= 1'b0;
      r_incA   <= 1'b0;
      r_clrA   <= 1'b0;
      r_weB    <= 1'b0;
      r_incB   <= 1'b0;
      r_clrB   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sub    <= w_sub_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bubble <= w_bubble_nxt;
      r_weA    <= w_weA;
      r_incA   <= w_incA;
      r_clrA   <= w_clrA;
      r_weB    <= w_weB;
      r_incB   <= w_incB;
      r_clrB   <= w_clrB;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  // r_cnt/r_sub name the next step to execute; a step advances only after a non-bubble cycle,
  // and a stalled edge parks the advanced position behind a bubble instead of repeating it.
  always_comb begin
    w_state_nxt  = r_state;
    w_sub_nxt    = r_sub;
    w_cnt_nxt    = r_cnt;
    w_sub_adv    = r_sub;
    w_cnt_adv    = r_cnt;
    w_bubble_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_CLR;
      end
      S_CLR: begin
        w_state_nxt = S_LOAD;
        w_cnt_nxt   = '0;
      end
      S_LOAD: begin
        if (!r_bubble) w_cnt_adv = r_cnt + 1'b1;
        w_cnt_nxt = w_cnt_adv;
        if (bus.stall)                  w_bubble_nxt = 1'b1;
        else if (w_cnt_adv == LOAD_END) w_state_nxt  = S_REWIND;
      end
      S_REWIND: begin
        w_state_nxt = S_PROC;
        w_sub_nxt   = SUB_R0;
        w_cnt_nxt   = '0;
      end
      S_PROC: begin
        if (!r_bubble) begin
          case (r_sub)
            SUB_R0:  w_sub_adv = SUB_R1;
            SUB_R1:  w_sub_adv = SUB_W;
            default: begin
              w_sub_adv = SUB_R0;
              w_cnt_adv = r_cnt + 1'b1;
            end
          endcase
        end
        w_sub_nxt = w_sub_adv;
        w_cnt_nxt = w_cnt_adv;
        if (bus.stall)                  w_bubble_nxt = 1'b1;
        else if (w_cnt_adv == PAIR_END) w_state_nxt  = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_active = !w_bubble_nxt;
    w_weA    = (w_state_nxt == S_LOAD) && w_active;
    w_incA   = ((w_state_nxt == S_LOAD) && w_active) ||
               ((w_state_nxt == S_PROC) && w_active && (w_sub_nxt != SUB_W));
    w_clrA   = (w_state_nxt == S_CLR) || (w_state_nxt == S_REWIND);
    w_weB    = (w_state_nxt == S_PROC) && w_active && (w_sub_nxt == SUB_R1);
    w_incB   = (w_state_nxt == S_PROC) && w_active && (w_sub_nxt == SUB_W);
    w_clrB   = (w_state_nxt == S_CLR);
    w_busy   = (w_state_nxt == S_CLR) || (w_state_nxt == S_LOAD) ||
               (w_state_nxt == S_REWIND) || (w_state_nxt == S_PROC);
    w_done   = (w_state_nxt == S_DONE);
  end

  assign bus.weA   = r_weA;
  assign bus.incA  = r_incA;
  assign bus.clrA  = r_clrA;
  assign bus.weB   = r_weB;
  assign bus.incB  = r_incB;
  assign bus.clrB  = r_clrB;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.phase = r_state;

endmodule

// File: doc/pair_xfer_sequencer.md
Name: pair_xfer_sequencer

Overview:
- Start/done-driven sequencer for the two-memory datapath. Memory A is a write/increment-address buffer; memory B is the pairwise result buffer.
- Loads A_DEPTH words into memory A, rewinds A, then steps through A in pairs. One datapath result per pair is written into memory B.
- Replaces free-running timing with an explicit FSM, a stall input and a busy/done handshake. Sits between the top-level control and the memory address counters and write enables.

Parameters:
- A_DEPTH, 8, words loaded into memory A; must be even and >= 2; B receives A_DEPTH/2 words.
- CNT_W, 4, width of the internal word/pair counters; must satisfy 2^CNT_W > A_DEPTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request one full sequence; sampled only in IDLE.
- stall  input  1  freeze the sequence in LOAD/PROC while high.
- weA  output  1  memory A write enable.
- incA  output  1  memory A address increment.
- clrA  output  1  memory A address clear to 0.
- weB  output  1  memory B write enable.
- incB  output  1  memory B address increment.
- clrB  output  1  memory B address clear to 0.
- busy  output  1  sequence in progress (CLR through PROC).
- done  output  1  one-cycle completion pulse.
- phase  output  3  current state code, for debug.

Behaviour:
- All outputs are registered Moore outputs: they reflect the state entered at the preceding rising edge.
- Reset (async, any time, including mid-sequence): state IDLE, counters 0, all outputs 0, phase 0.
- States and phase codes: IDLE=0, CLR=1, LOAD=2, REWIND=3, PROC=4, DONE=5. Codes 6 and 7 are unreachable and recover to IDLE on the next edge.
- IDLE: all strobes 0, busy=0. If start=1 at an edge, go to CLR; otherwise stay. start in any other state is ignored, including in DONE.
- CLR (1 cycle): clrA=1, clrB=1, busy=1. Next state is LOAD with word count 0. stall is ignored.
- LOAD: each active cycle drives weA=1 and incA=1 together (write at current address, advance at edge). The word count increments each active cycle. After A_DEPTH active cycles, go to REWIND.
- REWIND (1 cycle): clrA=1, other strobes 0. stall is ignored. Next state is PROC, sub-step R0, pair count 0.
- PROC: each pair is three active cycles.
  - R0: incA=1 (datapath captures operand 0).
  - R1: incA=1, weB=1 (datapath combines with operand 1; result written to B).
  - W: incB=1.
  - After the W of pair A_DEPTH/2-1, go to DONE. Otherwise return to R0 with pair count +1.
- DONE (1 cycle): done=1, busy=0, strobes 0. Next state is IDLE.
- stall handling:
  - If stall=1 at an edge while in, or transitioning within, LOAD or PROC, the following cycle is a bubble. In a bubble all strobes are 0, busy stays 1, and state, sub-step and counters hold.
  - The sequence resumes exactly at the held step once stall drops.
  - A stall covering the LOAD->REWIND or PROC->DONE edge delays that transition by one cycle per stalled edge.
- Unstalled timing with A_DEPTH=8, start seen at edge 0:
  - cycle 1: CLR
  - cycles 2-9: LOAD
  - cycle 10: REWIND
  - cycles 11-22: PROC
  - cycle 23: DONE
  - Generally, done occurs 3 + A_DEPTH + 3*A_DEPTH/2 cycles after the start edge.
- Invariants:
  - weA and weB are never high in the same cycle.
  - clrA is never high together with incA.
  - weA total per sequence = A_DEPTH; weB total = incB total = A_DEPTH/2; incA total = 2*A_DEPTH.

Test Plan:
- Basic run (A_DEPTH=8): start pulse at edge 0, stall=0 -> clrA/clrB high in cycle 1; weA=incA=1 in cycles 2-9; clrA in cycle 10; weB in cycles 12,15,18,21; incB in cycles 13,16,19,22; done only in cycle 23; busy high cycles 1-22.
- Stall in LOAD: stall high for 3 edges after the 4th weA -> 3 all-zero bubble cycles, still 8 weA total, done in cycle 26.
- Stall in PROC: stall held high across the R1 edge of pair 2 -> no duplicate or skipped weB; exactly 4 weB and 4 incB; done delayed by the stall length.
- start ignored: start held high throughout the first sequence -> no restart mid-run; a new sequence (CLR) begins only from IDLE, i.e. the cycle after DONE plus one edge.
- Reset mid-PROC: assert reset asynchronously during pair 1 -> all outputs 0 immediately, phase=0; a subsequent start gives a full clean 23-cycle sequence.
- Parameter A_DEPTH=2 -> 2 LOAD cycles, 1 pair (one weB, one incB), done 8 cycles after the start edge.
